// File: rtl/merge_out_packer_if.sv
// merge_out_packer_if
//   Bundles the upstream FWFT FIFO head, the flush handshake and the
//   downstream line channel of the output packer.
//   Signals:
//     i_data / i_empty / o_read    upstream FIFO head tuple and dequeue
//     i_flush / o_flush_done       flush request pulse and completion pulse
//     o_line / o_line_valid /
//     i_line_ready                 assembled line and its valid/ready handshake
//     o_line_count                 lines accepted by the consumer
//     o_busy                       packer holds data or has work pending
//   Modports: slave = packer side, master = environment side.
interface merge_out_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int P          = 4,
    parameter int LINE_WIDTH = 512
);
    logic [P*DATA_WIDTH-1:0] i_data;
    logic                    i_empty;
    logic                    o_read;
    logic                    i_flush;
    logic [LINE_WIDTH-1:0]   o_line;
    logic                    o_line_valid;
    logic                    i_line_ready;
    logic                    o_flush_done;
    logic [31:0]             o_line_count;
    logic                    o_busy;

    modport slave (
        input  i_data, i_empty, i_flush, i_line_ready,
        output o_read, o_line, o_line_valid, o_flush_done, o_line_count, o_busy
    );

    modport master (
        output i_data, i_empty, i_flush, i_line_ready,
        input  o_read, o_line, o_line_valid, o_flush_done, o_line_count, o_busy
    );
endinterface

// File: rtl/merge_out_packer.sv
// merge_out_packer
//   Packs P*DATA_WIDTH-bit tuples from a first-word-fall-through FIFO into
//   LINE_WIDTH-bit lines. A flush pads and emits any partial line.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous active-high reset
//     bus    merge_out_packer_if.slave (FIFO head, flush, line channel, status)
module merge_out_packer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    P          = 4,
    parameter int                    LINE_WIDTH = 512,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b1}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    merge_out_packer_if.slave     bus
);
    localparam int TW    = P * DATA_WIDTH;
    localparam int BEATS = LINE_WIDTH / TW;
    localparam int CW    = $clog2(BEATS + 1);

    logic [TW-1:0]         acc [BEATS];
    logic [CW-1:0]         acc_cnt;
    logic                  flush_pend;
    logic                  line_valid;
    logic                  flush_done;
    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_nxt;
    logic [31:0]           line_count;

    logic                  out_free;
    logic                  full;
    logic                  xfer;
    logic                  rd;
    logic [CW-1:0]         wr_idx;

    always_comb begin
        out_free = ~line_valid | bus.i_line_ready;
        full     = (acc_cnt == CW'(BEATS));
        xfer     = out_free & (full | (flush_pend & (acc_cnt != '0)));
        // While a line is stuck, a full accumulator may only refill on the
        // same edge that moves it into the output register.
        rd       = ~i_rst & ~bus.i_empty & ~flush_pend & (~full | xfer);
        wr_idx   = xfer ? '0 : acc_cnt;
        line_nxt = '0;
        for (int k = 0; k < BEATS; k++) begin
            // Slots beyond acc_cnt only exist on a flush transfer; a full
            // accumulator never takes the pad branch.
            line_nxt[k*TW +: TW] = (CW'(k) < acc_cnt) ? acc[k] : {P{PAD_VALUE}};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < BEATS; k++) acc[k] <= '0;
        end else if (rd) begin
            for (int k = 0; k < BEATS; k++) begin
                if (CW'(k) == wr_idx) acc[k] <= bus.i_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_cnt <= '0;
        end else if (rd && xfer) begin
            acc_cnt <= CW'(1);
        end else if (rd) begin
            acc_cnt <= acc_cnt + CW'(1);
        end else if (xfer) begin
            acc_cnt <= '0;
        end
    end

    // A flush completes once the accumulator is drained; the output register
    // may still hold the last line at that point.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= flush_pend & (acc_cnt == '0);
            if (flush_pend) begin
                if (acc_cnt == '0) flush_pend <= 1'b0;
            end else if (bus.i_flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            line_q     <= '0;
            line_valid <= 1'b0;
            line_count <= '0;
        end else begin
            if (xfer) begin
                line_q     <= line_nxt;
                line_valid <= 1'b1;
            end else if (bus.i_line_ready) begin
                line_valid <= 1'b0;
            end
            if (line_valid && bus.i_line_ready) line_count <= line_count + 32'd1;
        end
    end

    assign bus.o_read       = rd;
    assign bus.o_line       = line_q;
    assign bus.o_line_valid = line_valid;
    assign bus.o_flush_done = flush_done;
    assign bus.o_line_count = line_count;
    assign bus.o_busy       = (acc_cnt != '0) | line_valid | flush_pend;

endmodule

// File: tb/tb_merge_out_packer.sv
// tb_merge_out_packer
//   Directed bench for merge_out_packer at default parameters. A small
//   FWFT FIFO model feeds tuples; a monitor records every accepted line.
module tb_merge_out_packer;
    localparam int TW = 128;
    localparam int LW = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    merge_out_packer_if #(.DATA_WIDTH(32), .P(4), .LINE_WIDTH(LW)) bus ();

    merge_out_packer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    logic [TW-1:0] mem [64];
    int            wr_cnt = 0;
    int            rd_ptr;
    logic          flush = 1'b0;
    logic          ready = 1'b0;

    assign bus.i_data       = mem[rd_ptr[5:0]];
    assign bus.i_empty      = (rd_ptr >= wr_cnt);
    assign bus.i_flush      = flush;
    assign bus.i_line_ready = ready;

    always @(posedge clk or posedge rst) begin
        if (rst) rd_ptr <= 0;
        else if (bus.o_read) rd_ptr <= rd_ptr + 1;
    end

    logic [LW-1:0] cap [8];
    int            nlines;
    always @(posedge clk or posedge rst) begin
        if (rst) nlines <= 0;
        else if (bus.o_line_valid && ready) begin
            if (nlines < 8) cap[nlines] <= bus.o_line;
            nlines <= nlines + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] tup(input int k);
        return {4{k[31:0]}};
    endfunction

    function automatic logic [LW-1:0] mkline(input logic [TW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    localparam logic [TW-1:0] PAD = {TW{1'b1}};

    task automatic do_reset();
        rst    = 1'b1;
        flush  = 1'b0;
        wr_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) mem[i] = tup(base + i);
    endtask

    task automatic wait_lines(input string tag, input int n);
        int c;
        c = 0;
        while (nlines < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk_val(tag, LW'(nlines), LW'(n));
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (bus.o_flush_done) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  cyc;
        int  nd;
        bit  stable;
        logic [LW-1:0] held;

        // Reset state
        ready = 1'b1;
        load(1, 8);
        #2;
        chk_val("rst_read",  LW'(bus.o_read), '0);
        do_reset();
        chk_val("rst_line",  bus.o_line, '0);
        chk_val("rst_valid", LW'(bus.o_line_valid), '0);
        chk_val("rst_count", LW'(bus.o_line_count), '0);
        chk_val("rst_busy",  LW'(bus.o_busy), '0);
        chk_val("rst_done",  LW'(bus.o_flush_done), '0);

        // Two full lines, streaming
        wr_cnt = 8;
        cyc = 0;
        while (rd_ptr < 8 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk_val("stream_cycles", LW'(cyc), LW'(8));
        wait_lines("stream_nlines", 2);
        chk_val("stream_line0", cap[0], mkline(tup(1), tup(2), tup(3), tup(4)));
        chk_val("stream_line1", cap[1], mkline(tup(5), tup(6), tup(7), tup(8)));
        repeat (2) @(negedge clk);
        chk_val("stream_count", LW'(bus.o_line_count), LW'(2));
        chk_val("stream_busy",  LW'(bus.o_busy), '0);

        // Backpressure
        ready = 1'b1;
        load(1, 12);
        do_reset();
        wr_cnt = 12;
        cyc = 0;
        while (!bus.o_line_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        ready = 1'b0;
        held = bus.o_line;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_line !== held || !bus.o_line_valid) stable = 1'b0;
        end
        chk_val("bp_stable", LW'(stable), LW'(1));
        chk_val("bp_held",   held, mkline(tup(1), tup(2), tup(3), tup(4)));
        chk_val("bp_rdptr",  LW'(rd_ptr), LW'(8));
        chk_val("bp_read",   LW'(bus.o_read), '0);
        ready = 1'b1;
        #1;
        chk_val("bp_resume", LW'(bus.o_read), LW'(1));
        wait_lines("bp_nlines", 3);
        chk_val("bp_line0", cap[0], mkline(tup(1), tup(2), tup(3), tup(4)));
        chk_val("bp_line1", cap[1], mkline(tup(5), tup(6), tup(7), tup(8)));
        chk_val("bp_line2", cap[2], mkline(tup(9), tup(10), tup(11), tup(12)));
        chk_val("bp_rdall", LW'(rd_ptr), LW'(12));

        // Partial line flush
        load(1, 2);
        do_reset();
        wr_cnt = 2;
        cyc = 0;
        while (rd_ptr < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        pulse_flush();
        count_done(15, nd);
        chk_val("pflush_done",   LW'(nd), LW'(1));
        chk_val("pflush_nlines", LW'(nlines), LW'(1));
        chk_val("pflush_line",   cap[0], mkline(tup(1), tup(2), PAD, PAD));
        chk_val("pflush_count",  LW'(bus.o_line_count), LW'(1));

        // Flush with empty accumulator: done exactly two cycles later
        do_reset();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_val("eflush_d1", LW'(bus.o_flush_done), '0);
        @(negedge clk);
        chk_val("eflush_d2", LW'(bus.o_flush_done), LW'(1));
        @(negedge clk);
        chk_val("eflush_d3", LW'(bus.o_flush_done), '0);
        chk_val("eflush_nlines", LW'(nlines), '0);
        chk_val("eflush_count",  LW'(bus.o_line_count), '0);

        // Flush coincident with the 4th tuple read
        load(1, 4);
        do_reset();
        wr_cnt = 4;
        cyc = 0;
        while (rd_ptr < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        pulse_flush();
        count_done(15, nd);
        chk_val("fflush_done",   LW'(nd), LW'(1));
        chk_val("fflush_nlines", LW'(nlines), LW'(1));
        chk_val("fflush_line",   cap[0], mkline(tup(1), tup(2), tup(3), tup(4)));

        // Asynchronous reset mid-line
        ready = 1'b0;
        load(1, 7);
        do_reset();
        wr_cnt = 7;
        repeat (12) @(negedge clk);
        chk_val("arst_pre_valid", LW'(bus.o_line_valid), LW'(1));
        chk_val("arst_pre_rd",    LW'(rd_ptr), LW'(7));
        #2;
        rst = 1'b1;
        #1;
        chk_val("arst_line",  bus.o_line, '0);
        chk_val("arst_valid", LW'(bus.o_line_valid), '0);
        chk_val("arst_busy",  LW'(bus.o_busy), '0);
        chk_val("arst_read",  LW'(bus.o_read), '0);
        load(17, 4);
        wr_cnt = 4;
        @(negedge clk);
        ready = 1'b1;
        rst = 1'b0;
        wait_lines("arst_nlines", 1);
        chk_val("arst_line0", cap[0], mkline(tup(17), tup(18), tup(19), tup(20)));
        @(negedge clk);
        chk_val("arst_count", LW'(bus.o_line_count), LW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
